// File: rtl/rand_shuffle_pkg.sv
// rand_shuffle_pkg
//   Shared types and helpers for the rand_shuffle block.
//   - state_t  : controller states (IDLE, SHUFFLE, EMIT)
//   - MASK_W   : width of the mask helper; covers every index for LEN <= 64
//   - mask_for : smallest all-ones value >= i, used to bound rejection sampling
package rand_shuffle_pkg;

  localparam int MASK_W = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHUFFLE = 2'd1,
    EMIT    = 2'd2
  } state_t;

  // Smear the highest set bit downwards; the result is the smallest 2^m-1
  // that is >= i (0 maps to 0, 1 to 1, 2 to 3, 5 to 7, ...).
  function automatic logic [MASK_W-1:0] mask_for(input logic [MASK_W-1:0] i);
    logic [MASK_W-1:0] m;
    m = i | (i >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

endpackage

// File: rtl/rand_shuffle.sv
// rand_shuffle
//   Fisher-Yates shuffle of the symbols 0..LEN-1 driven by an external LFSR
//   word, followed by a valid/ready stream of the resulting permutation.
// Ports:
//   clock        in   system clock, posedge
//   reset        in   synchronous active-high reset
//   start        in   begin a new shuffle (sampled in IDLE only)
//   rand_in      in   current LFSR state word
//   rand_advance out  step the LFSR; high on every cycle rand_in is consumed
//   busy         out  high whenever not IDLE
//   out_valid    out  element available
//   out_ready    in   consumer accepts the element
//   out_data     out  permutation element
//   out_last     out  marks the final element
module rand_shuffle
  import rand_shuffle_pkg::*;
#(
  parameter  int LEN        = 9,
  parameter  int RAND_WIDTH = 16,
  localparam int IDX_W      = $clog2(LEN)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [RAND_WIDTH-1:0] rand_in,
  output logic                  rand_advance,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_data,
  output logic                  out_last
);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_perm      [0:LEN-1];
  logic [IDX_W-1:0] w_perm_next [0:LEN-1];
  logic [IDX_W-1:0] r_i;
  logic [IDX_W-1:0] r_k;
  logic [IDX_W-1:0] r_out_data;
  logic             r_out_last;

  logic [MASK_W-1:0] w_j_wide;
  logic [IDX_W-1:0]  w_j;
  logic [IDX_W-1:0]  w_k_inc;
  logic              w_load;
  logic              w_accept;

  // Only the low IDX_W bits of the LFSR word are used as the draw.
  generate
    if (RAND_WIDTH > IDX_W) begin : g_rand_hi
      logic w_unused_rand_hi;
      assign w_unused_rand_hi = ^rand_in[RAND_WIDTH-1:IDX_W];
    end
  endgenerate

  // The comparison is done at mask width so a masked draw above i is caught
  // even when it does not fit a valid perm index.
  assign w_j_wide = MASK_W'(rand_in[IDX_W-1:0]) & mask_for(MASK_W'(r_i));
  assign w_j      = w_j_wide[IDX_W-1:0];
  assign w_accept = (r_state == SHUFFLE) && (w_j_wide <= MASK_W'(r_i));
  assign w_load   = (r_state == IDLE) && start;
  assign w_k_inc  = r_k + IDX_W'(1);

  // Per-element next value: identity on reset/start, otherwise the swap of
  // perm[i] and perm[j] on an accepted draw (j==i leaves the array alone).
  generate
    for (genvar gi = 0; gi < LEN; gi++) begin : g_perm
      always_comb begin
        w_perm_next[gi] = r_perm[gi];
        if (reset || w_load) begin
          w_perm_next[gi] = IDX_W'(gi);
        end else if (w_accept) begin
          if (IDX_W'(gi) == r_i) begin
            w_perm_next[gi] = r_perm[w_j];
          end else if (IDX_W'(gi) == w_j) begin
            w_perm_next[gi] = r_perm[r_i];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    r_perm <= w_perm_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    rand_advance = 1'b0;
    busy         = 1'b1;
    out_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = SHUFFLE;
      end
      SHUFFLE: begin
        rand_advance = 1'b1;
        if (w_accept && (r_i == IDX_W'(1))) w_state_next = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && r_out_last) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Index counters and the registered output element. On the final accept
  // the first element is taken from the post-swap array so out_data is
  // already correct in the first EMIT cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_i        <= '0;
      r_k        <= '0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) r_i <= IDX_W'(LEN - 1);
        end
        SHUFFLE: begin
          if (w_accept) begin
            if (r_i == IDX_W'(1)) begin
              r_k        <= '0;
              r_out_data <= w_perm_next[0];
              r_out_last <= 1'b0;
            end else begin
              r_i <= r_i - IDX_W'(1);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (r_out_last) begin
              r_k        <= '0;
              r_out_data <= '0;
              r_out_last <= 1'b0;
            end else begin
              r_k        <= w_k_inc;
              r_out_data <= r_perm[w_k_inc];
              r_out_last <= (w_k_inc == IDX_W'(LEN - 1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_out_data;
  assign out_last = r_out_last;

endmodule

// File: tb/tb_rand_shuffle.sv
// tb_rand_shuffle
//   Directed table of LEN=4 shuffles with hand-derived streams, multi-cycle
//   corner sequences (backpressure, start while busy, reset mid-operation),
//   and 1000 randomized LEN=9 runs checked against a Fisher-Yates model.
module tb_rand_shuffle;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // LEN=4 instance
  logic        start4;
  logic [15:0] rand4;
  logic        adv4, busy4, valid4, ready4, last4;
  logic [1:0]  data4;

  // LEN=9 instance
  logic        start9;
  logic [15:0] rand9;
  logic        adv9, busy9, valid9, ready9, last9;
  logic [3:0]  data9;

  rand_shuffle #(.LEN(4), .RAND_WIDTH(16)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .rand_in(rand4),
    .rand_advance(adv4), .busy(busy4), .out_valid(valid4),
    .out_ready(ready4), .out_data(data4), .out_last(last4)
  );

  rand_shuffle #(.LEN(9), .RAND_WIDTH(16)) dut9 (
    .clock(clock), .reset(reset), .start(start9), .rand_in(rand9),
    .rand_advance(adv9), .busy(busy9), .out_valid(valid9),
    .out_ready(ready9), .out_data(data9), .out_last(last9)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // LEN=4 bookkeeping
  logic [15:0] q4 [$];
  logic [1:0]  got4_d [$];
  logic        got4_l [$];
  int          adv_cnt4, busy_cnt4;
  logic        ready_mode4 = 1'b0;
  logic        spam4       = 1'b0;

  // LEN=9 bookkeeping
  logic [15:0] used9  [$];
  logic [3:0]  got9_d [$];
  logic        got9_l [$];

  typedef struct packed {
    logic [3:0][15:0] w;
    logic [2:0]       nw;
    logic [3:0][1:0]  exp;
    logic [2:0]       exp_adv;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] w0, w1, w2, w3,
                              input int nw,
                              input logic [1:0] e0, e1, e2, e3,
                              input int adv);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.nw = 3'(nw);
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    v.exp_adv = 3'(adv);
    return v;
  endfunction

  // One clock cycle: record pre-edge handshakes, advance, then update the
  // LFSR stand-ins and the input drivers for the next edge.
  task automatic tick();
    logic pre_rst, pre_adv4, pre_x4, pre_stall4, pre_l4, pre_adv9, pre_x9, pre_l9;
    logic [1:0] pre_d4;
    pre_rst    = reset;
    pre_adv4   = adv4;
    pre_x4     = valid4 && ready4;
    pre_stall4 = valid4 && !ready4;
    pre_d4     = data4;
    pre_l4     = last4;
    pre_adv9   = adv9;
    pre_x9     = valid9 && ready9;
    pre_l9     = last9;
    if (!pre_rst) begin
      if (pre_x4) begin got4_d.push_back(data4); got4_l.push_back(last4); end
      if (pre_x9) begin got9_d.push_back(data9); got9_l.push_back(last9); end
      if (pre_adv9) used9.push_back(rand9);
      if (busy4) busy_cnt4++;
      if (pre_adv4) adv_cnt4++;
    end
    @(posedge clock);
    #1;
    cyc++;
    if (pre_adv4 && q4.size() > 0) q4.delete(0);
    rand4 = (q4.size() > 0) ? q4[0] : 16'h0000;
    if (pre_adv9) rand9 = 16'($urandom);
    if (!pre_rst && pre_stall4) begin
      chk("stall_valid4", int'(valid4), 1);
      chk("stall_data4", int'(data4), int'(pre_d4));
      chk("stall_last4", int'(last4), int'(pre_l4));
    end
    if (!pre_rst && pre_x4 && pre_l4) chk("busy_fall4", int'(busy4), 0);
    if (!pre_rst && pre_x9 && pre_l9) chk("busy_fall9", int'(busy9), 0);
    ready4 = ready_mode4 ? ((cyc % 3) == 0) : 1'b1;
    start4 = spam4 && busy4 && ((cyc % 2) == 1);
    ready9 = ($urandom_range(0, 3) != 0);
  endtask

  task automatic load4(input vec_t v);
    q4.delete();
    for (int n = 0; n < int'(v.nw); n++) q4.push_back(v.w[n]);
    rand4 = q4[0];
  endtask

  task automatic run4();
    got4_d.delete();
    got4_l.delete();
    adv_cnt4  = 0;
    busy_cnt4 = 0;
    start4 = 1'b1;
    tick();
    for (int n = 0; n < 200 && busy4; n++) tick();
    chk("run4_timeout", int'(busy4), 0);
  endtask

  task automatic check_stream4(input string tag, input vec_t v);
    chk({tag, "_len"}, got4_d.size(), 4);
    for (int e = 0; e < 4; e++) begin
      if (e < got4_d.size()) begin
        chk($sformatf("%s_data%0d", tag, e), int'(got4_d[e]), int'(v.exp[e]));
        chk($sformatf("%s_last%0d", tag, e), int'(got4_l[e]), (e == 3) ? 1 : 0);
      end
    end
    chk({tag, "_adv"}, adv_cnt4, int'(v.exp_adv));
  endtask

  initial begin
    int hist [9][9];
    reset  = 1'b1;
    start4 = 1'b0; start9 = 1'b0;
    ready4 = 1'b1; ready9 = 1'b1;
    rand4  = 16'h0; rand9 = 16'($urandom);
    for (int p = 0; p < 9; p++) for (int s = 0; s < 9; s++) hist[p][s] = 0;

    vecs[0] = mk(16'h0001, 16'h0003, 16'h0002, 16'h0000, 4, 2'd3, 2'd0, 2'd2, 2'd1, 4);
    vecs[1] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 3, 2'd1, 2'd2, 2'd3, 2'd0, 3);
    vecs[2] = mk(16'h0003, 16'h0001, 16'h0001, 16'h0000, 3, 2'd0, 2'd2, 2'd1, 2'd3, 3);
    vecs[3] = mk(16'hFFFE, 16'h0007, 16'h0005, 16'h0002, 4, 2'd3, 2'd0, 2'd1, 2'd2, 4);
    vecs[4] = mk(16'h0005, 16'h0006, 16'h0001, 16'h0000, 3, 2'd0, 2'd3, 2'd2, 2'd1, 3);

    // Reset state
    tick(); tick();
    chk("rst_busy4", int'(busy4), 0);
    chk("rst_adv4", int'(adv4), 0);
    chk("rst_valid4", int'(valid4), 0);
    chk("rst_data4", int'(data4), 0);
    chk("rst_last4", int'(last4), 0);
    chk("rst_busy9", int'(busy9), 0);
    chk("rst_valid9", int'(valid9), 0);
    reset = 1'b0;
    tick();
    chk("idle_hold_busy4", int'(busy4), 0);

    // Directed table, out_ready held high
    for (int v = 0; v < 5; v++) begin
      load4(vecs[v]);
      run4();
      check_stream4($sformatf("vec%0d", v), vecs[v]);
      chk($sformatf("vec%0d_busy_cycles", v), busy_cnt4, int'(vecs[v].exp_adv) + 4);
      $display("vec%0d: stream %0d %0d %0d %0d, advances %0d, busy cycles %0d", v,
               (got4_d.size() > 0) ? got4_d[0] : 2'd0, (got4_d.size() > 1) ? got4_d[1] : 2'd0,
               (got4_d.size() > 2) ? got4_d[2] : 2'd0, (got4_d.size() > 3) ? got4_d[3] : 2'd0,
               adv_cnt4, busy_cnt4);
    end

    // Backpressure: out_ready toggles 1,0,0,...
    ready_mode4 = 1'b1;
    load4(vecs[0]);
    run4();
    check_stream4("bp", vecs[0]);
    ready_mode4 = 1'b0;
    ready4 = 1'b1;
    $display("backpressure: %0d transfers, busy cycles %0d", got4_d.size(), busy_cnt4);

    // start pulses while busy must not disturb the run
    spam4 = 1'b1;
    load4(vecs[0]);
    run4();
    spam4 = 1'b0;
    start4 = 1'b0;
    check_stream4("spam", vecs[0]);
    chk("spam_busy_cycles", busy_cnt4, 8);
    tick();
    chk("spam_no_restart", int'(busy4), 0);
    $display("start-while-busy: busy cycles %0d", busy_cnt4);

    // Reset during SHUFFLE (after the i=3 accept, so i=2)
    load4(vecs[0]);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("rst_shuf_valid", int'(valid4), 0);
    chk("rst_shuf_busy", int'(busy4), 0);
    chk("rst_shuf_adv", int'(adv4), 0);
    reset = 1'b0;
    tick();
    load4(vecs[0]);
    run4();
    check_stream4("after_rst", vecs[0]);
    $display("reset during shuffle, rerun transfers %0d", got4_d.size());

    // Reset during EMIT with k=1
    load4(vecs[0]);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int n = 0; n < 50 && !valid4; n++) tick();
    chk("emit_reach", int'(valid4), 1);
    tick();
    chk("emit_k1_data", int'(data4), 0);
    reset = 1'b1;
    tick();
    chk("rst_emit_valid", int'(valid4), 0);
    chk("rst_emit_busy", int'(busy4), 0);
    chk("rst_emit_adv", int'(adv4), 0);
    reset = 1'b0;
    tick();
    chk("rst_emit_stays_idle", int'(busy4), 0);
    $display("reset during emit done");

    // Randomized LEN=9 runs, back to back, against a Fisher-Yates model
    for (int run = 0; run < 1000; run++) begin
      int perm [9];
      int idx, mism, seen, lastbits;
      logic short_src;
      used9.delete();
      got9_d.delete();
      got9_l.delete();
      start9 = 1'b1;
      tick();
      start9 = 1'b0;
      for (int n = 0; n < 1000 && busy9; n++) tick();
      chk("run9_timeout", int'(busy9), 0);

      for (int p = 0; p < 9; p++) perm[p] = p;
      idx = 0;
      short_src = 1'b0;
      for (int i = 8; i >= 1; i--) begin
        int m;
        logic done;
        m = 1;
        while (m - 1 < i) m = m * 2;
        done = 1'b0;
        while (!done && idx < used9.size()) begin
          int j, t;
          j = int'(used9[idx]) % m;
          idx++;
          if (j <= i) begin
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            done = 1'b1;
          end
        end
        if (!done) short_src = 1'b1;
      end
      chk("words9_consumed", (short_src ? -1 : idx), used9.size());
      chk("len9", got9_d.size(), 9);
      mism = 0; seen = 0; lastbits = 0;
      for (int p = 0; p < 9; p++) begin
        if (p < got9_d.size()) begin
          if (int'(got9_d[p]) != perm[p]) mism++;
          if (got9_d[p] < 4'd9) seen = seen | (1 << got9_d[p]);
          if (got9_l[p]) lastbits = lastbits | (1 << p);
          if (got9_d[p] < 4'd9) hist[p][got9_d[p]]++;
        end
      end
      chk("stream9_mismatches", mism, 0);
      chk("perm9_symbols", seen, 9'h1FF);
      chk("last9_position", lastbits, 9'h100);
      $display("run9 %0d: %0d draws, %0d elements", run, used9.size(), got9_d.size());
    end

    // Per-position chi-square against uniform (8 degrees of freedom)
    for (int p = 0; p < 9; p++) begin
      real chi, e, d;
      chi = 0.0;
      e = 1000.0 / 9.0;
      for (int s = 0; s < 9; s++) begin
        d = real'(hist[p][s]) - e;
        chi = chi + d * d / e;
      end
      checks++;
      if (chi >= 30.0) begin
        errors++;
        $display("FAIL chi2_pos%0d: got %f, expected < 30.0", p, chi);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rand_shuffle.md
# rand_shuffle

Generates a uniformly random permutation of the symbols 0..LEN-1 with a Fisher-Yates shuffle, then streams it out one element at a time over a valid/ready handshake. It sits directly downstream of the design's LFSR. It consumes the LFSR's current state word as its random source, and its advance output drives the LFSR's advance input. The Sudoku generator uses it to pick randomized candidate-value and cell orderings.

## Interface
- LEN, default 9: number of symbols; legal range 2..64.
- RAND_WIDTH, default 16: width of the random input; must be ≥ IDX_W.
- IDX_W, derived as $clog2(LEN): width of each element.

- clock  in  1  system clock; all state updates on the posedge.
- reset  in  1  reset; synchronous, active-high.
- start  in  1  begins a new shuffle; sampled only in IDLE.
- rand_in  in  RAND_WIDTH  current LFSR state word.
- rand_advance  out  1  steps the LFSR; high exactly on cycles where rand_in is consumed.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  element available.
- out_ready  in  1  consumer accepts the element.
- out_data  out  IDX_W  permutation element.
- out_last  out  1  qualifies the final element (index LEN-1).

## Operation
- Registers:
  - perm[0..LEN-1], each IDX_W wide;
  - i, the shuffle index;
  - k, the emit index;
  - state ∈ {IDLE, SHUFFLE, EMIT}.
- IDLE, with start=1:
  - perm[n] := n for every n;
  - i := LEN-1;
  - go to SHUFFLE.
- IDLE, with start=0: hold.
- SHUFFLE, one attempt per cycle:
  - rand_advance=1;
  - mask(i) = smallest 2^m-1 ≥ i;
  - j = rand_in[IDX_W-1:0] & mask(i).
- SHUFFLE, if j ≤ i (accept):
  - swap perm[i] and perm[j]; j==i is a legal no-op swap;
  - if i==1: k := 0, go to EMIT;
  - otherwise i := i-1.
- SHUFFLE, if j > i (reject): no change to perm or i; retry next cycle with the advanced rand_in.
- Rejection sampling keeps the selection unbiased. Expected attempts per index are < 2.
- EMIT:
  - out_valid=1, out_data=perm[k], out_last=(k==LEN-1);
  - on a transfer (out_valid & out_ready): k := k+1;
  - on a transfer with out_last: go to IDLE.
- start is ignored while busy.
- perm is not cleared on return to IDLE. It is re-initialised on the next start.
- The block never inspects the LFSR seed. A zero rand_in stream is legal and always yields j=0.

## Timing
- Reset values:
  - state=IDLE, busy=0, rand_advance=0;
  - out_valid=0, out_data=0, out_last=0;
  - i=0, k=0, perm[n]=n.
- Reset overrides start and any in-flight shuffle or stream. busy=0 and out_valid=0 in the cycle after reset is sampled. No partial stream resumes.
- rand_advance is combinational: (state==SHUFFLE). The LFSR steps on the same edge at which rand_in is sampled, so each attempt sees a fresh word.
- start sampled at edge t puts the block in SHUFFLE from cycle t+1.
- Minimum SHUFFLE duration is LEN-1 cycles (no rejects).
- out_valid rises the cycle after the final accept.
- EMIT lasts ≥ LEN cycles and runs exactly LEN cycles when out_ready is held high.
- out_data and out_last are driven from registers and stay stable while out_valid=1 and out_ready=0.
- busy falls the cycle after the out_last transfer. A new start is accepted from that cycle onward.

## Structure
- Shared package rand_shuffle_pkg holds:
  - state_t enum {IDLE, SHUFFLE, EMIT};
  - function mask_for(i), returning the smallest all-ones value ≥ i.
- The perm array is a flat register array with a single swap port; no RAM.
- No sub-module is needed. The LFSR is instantiated beside this block by the parent, not inside it.

## Test plan
- Basic shuffle, LEN=4, out_ready=1:
  - rand_in per SHUFFLE cycle = 1, 3, 2, 0 (the 3 at i=2 is rejected);
  - rand_advance is high for exactly 4 cycles;
  - stream is 3, 0, 2, 1, with out_last on the 1.
- All-zero source, LEN=4, rand_in=0 throughout:
  - exactly 3 SHUFFLE cycles;
  - stream is 1, 2, 3, 0.
- Backpressure, same as the basic case:
  - toggle out_ready 1,0,0,1,...;
  - each element holds steady while stalled;
  - exactly 4 transfers; busy falls the cycle after the last.
- start while busy: a start pulse during SHUFFLE and again during EMIT has no effect on the stream or the cycle count.
- Reset mid-operation:
  - assert reset during SHUFFLE (i=2) and again during EMIT (k=1);
  - next cycle out_valid=0, busy=0, rand_advance=0;
  - a fresh start after the SHUFFLE-time reset reproduces the basic-case stream from identity.
- Integration with the real LFSR, LEN=9:
  - 1000 back-to-back runs;
  - every stream is a permutation of 0..8, with out_last only on the 9th element;
  - per-position symbol histogram is within χ² bounds of uniform.
